variable_proposer: RTL and testbench

VARIABLE_PROPOSER -- requirements
Module: variable_proposer

---
 rtl/variable_pkg.sv | 26 ++
 rtl/proposal_arith.sv | 92 +++++++++
 rtl/variable_proposer.sv | 169 ++++++++++++++++
 tb/tb_variable_proposer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/variable_pkg.sv
// Shared type codes and FSM state encoding for the variable proposer.
package variable_pkg;

  // Variable type codes as presented on in_choosen_type.
  typedef enum logic [1:0] {
    TYPE_BOOL    = 2'd0,
    TYPE_INT     = 2'd1,
    TYPE_DISC    = 2'd2,
    TYPE_ILLEGAL = 2'd3
  } var_type_e;

  // Proposal FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_VALID   = 3'd4
  } state_e;

  // True when the type code names a variable kind we can propose for.
  function automatic logic is_legal_type(input logic [1:0] code);
    return (code != TYPE_ILLEGAL);
  endfunction

endpackage

// File: rtl/proposal_arith.sv
// Combinational new-value generator: boolean flip, reflected/clamped
// integer step, and wrapping discrete step.
import variable_pkg::*;

module proposal_arith #(
  parameter int VALUE_WIDTH = 16
) (
  input  logic [1:0]             var_type,
  input  logic [VALUE_WIDTH-1:0] old_value,
  input  logic [3:0]             random_word,
  input  logic [VALUE_WIDTH-1:0] int_min,
  input  logic [VALUE_WIDTH-1:0] int_max,
  input  logic [VALUE_WIDTH-1:0] discrete_max,
  output logic [VALUE_WIDTH-1:0] new_value
);

  localparam int W = VALUE_WIDTH;

  // One extra bit so old +/- 8 can never wrap before the bound checks.
  logic signed [W:0] old_ext_s;
  logic signed [W:0] min_ext_s;
  logic signed [W:0] max_ext_s;
  logic signed [W:0] mag_s;
  logic signed [W:0] fwd_s;
  logic signed [W:0] rev_s;
  logic signed [W:0] pick_s;
  logic signed [W:0] clamp_s;
  logic              dir_neg_s;
  logic [W-1:0]      bool_s;
  logic [W-1:0]      int_s;
  logic [W-1:0]      disc_s;

  // Integer step: try the random direction, reflect on a bound hit, then clamp.
  always_comb begin
    old_ext_s = {old_value[W-1], old_value};
    min_ext_s = {int_min[W-1], int_min};
    max_ext_s = {int_max[W-1], int_max};
    mag_s     = {{(W-2){1'b0}}, random_word[2:0]} + {{W{1'b0}}, 1'b1};
    dir_neg_s = random_word[3];
    if (dir_neg_s) begin
      fwd_s = old_ext_s - mag_s;
      rev_s = old_ext_s + mag_s;
    end else begin
      fwd_s = old_ext_s + mag_s;
      rev_s = old_ext_s - mag_s;
    end
    if ((fwd_s > max_ext_s) || (fwd_s < min_ext_s)) begin
      pick_s = rev_s;
    end else begin
      pick_s = fwd_s;
    end
    if (pick_s > max_ext_s) begin
      clamp_s = max_ext_s;
    end else if (pick_s < min_ext_s) begin
      clamp_s = min_ext_s;
    end else begin
      clamp_s = pick_s;
    end
    int_s = clamp_s[W-1:0];
  end

  // Boolean flip and wrapping discrete step (discrete values are unsigned).
  always_comb begin
    bool_s = {{(W-1){1'b0}}, ~old_value[0]};
    if (random_word[0] == 1'b0) begin
      if (old_value >= discrete_max) begin
        disc_s = {W{1'b0}};
      end else begin
        disc_s = old_value + {{(W-1){1'b0}}, 1'b1};
      end
    end else begin
      if (old_value == {W{1'b0}}) begin
        disc_s = discrete_max;
      end else if (old_value > discrete_max) begin
        disc_s = discrete_max;
      end else begin
        disc_s = old_value - {{(W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Select the result for the requested variable kind.
  always_comb begin
    case (var_type)
      TYPE_BOOL: new_value = bool_s;
      TYPE_INT:  new_value = int_s;
      TYPE_DISC: new_value = disc_s;
      default:   new_value = {W{1'b0}};
    endcase
  end

endmodule

// File: rtl/variable_proposer.sv
// Proposes a new value for one variable: reads its current value from the
// assignment memory, computes a neighbour value and offers it over a
// valid/ready handshake.
import variable_pkg::*;

module variable_proposer #(
  parameter int MAX_BIT_WIDTH_OF_VARIABLES_INDEX = 8,
  parameter int VALUE_WIDTH                      = 16
) (
  input  logic                                        in_clock,
  input  logic                                        in_reset,
  input  logic                                        in_start,
  input  logic [1:0]                                  in_choosen_type,
  input  logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0] in_choosen_index,
  input  logic [3:0]                                  in_random,
  input  logic [VALUE_WIDTH-1:0]                      in_int_min,
  input  logic [VALUE_WIDTH-1:0]                      in_int_max,
  input  logic [VALUE_WIDTH-1:0]                      in_discrete_max,
  output logic                                        out_mem_read_enable,
  output logic [1:0]                                  out_mem_read_type,
  output logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0] out_mem_read_index,
  input  logic [VALUE_WIDTH-1:0]                      in_mem_read_data,
  output logic                                        out_proposal_valid,
  input  logic                                        in_proposal_ready,
  output logic [1:0]                                  out_proposal_type,
  output logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0] out_proposal_index,
  output logic [VALUE_WIDTH-1:0]                      out_old_value,
  output logic [VALUE_WIDTH-1:0]                      out_new_value,
  output logic                                        out_busy,
  output logic                                        out_error
);

  localparam int IW = MAX_BIT_WIDTH_OF_VARIABLES_INDEX;
  localparam int VW = VALUE_WIDTH;

  state_e          state_r;
  state_e          state_nxt_s;
  logic [1:0]      type_r;
  logic [IW-1:0]   index_r;
  logic [3:0]      random_r;
  logic [VW-1:0]   old_r;
  logic [VW-1:0]   new_r;
  logic [VW-1:0]   arith_new_s;
  logic            read_en_r;
  logic            valid_r;
  logic            busy_r;
  logic            error_r;
  logic            read_en_nxt_s;
  logic            valid_nxt_s;
  logic            busy_nxt_s;
  logic            error_nxt_s;

  proposal_arith #(
    .VALUE_WIDTH(VW)
  ) u_arith (
    .var_type     (type_r),
    .old_value    (old_r),
    .random_word  (random_r),
    .int_min      (in_int_min),
    .int_max      (in_int_max),
    .discrete_max (in_discrete_max),
    .new_value    (arith_new_s)
  );

  // FSM state register.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_start) begin
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ: state_nxt_s = ST_WAIT;
      ST_WAIT: state_nxt_s = ST_COMPUTE;
      ST_COMPUTE: begin
        if (is_legal_type(type_r)) begin
          state_nxt_s = ST_VALID;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_VALID: begin
        if (in_proposal_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_VALID;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every flag is a flop output.
  always_comb begin
    read_en_nxt_s = (state_nxt_s == ST_READ);
    valid_nxt_s   = (state_nxt_s == ST_VALID);
    busy_nxt_s    = (state_nxt_s != ST_IDLE);
    if ((state_nxt_s == ST_COMPUTE) && !is_legal_type(type_r)) begin
      error_nxt_s = 1'b1;
    end else begin
      error_nxt_s = 1'b0;
    end
  end

  // Registered status and handshake flags.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      read_en_r <= 1'b0;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      read_en_r <= read_en_nxt_s;
      valid_r   <= valid_nxt_s;
      busy_r    <= busy_nxt_s;
      error_r   <= error_nxt_s;
    end
  end

  // Capture request, old value and computed value; held untouched in VALID.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      type_r   <= 2'd0;
      index_r  <= {IW{1'b0}};
      random_r <= 4'd0;
      old_r    <= {VW{1'b0}};
      new_r    <= {VW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_start) begin
            type_r   <= in_choosen_type;
            index_r  <= in_choosen_index;
            random_r <= in_random;
          end
        end
        ST_WAIT:    old_r <= in_mem_read_data;
        ST_COMPUTE: new_r <= arith_new_s;
        default: begin
          old_r <= old_r;
        end
      endcase
    end
  end

  assign out_mem_read_enable = read_en_r;
  assign out_mem_read_type   = type_r;
  assign out_mem_read_index  = index_r;
  assign out_proposal_valid  = valid_r;
  assign out_proposal_type   = type_r;
  assign out_proposal_index  = index_r;
  assign out_old_value       = old_r;
  assign out_new_value       = new_r;
  assign out_busy            = busy_r;
  assign out_error           = error_r;

endmodule

// File: tb/tb_variable_proposer.sv
// Directed plus light random test of variable_proposer with a proposal scoreboard.
module tb_variable_proposer;

  localparam int IW = 8;
  localparam int VW = 16;

  logic          in_clock = 1'b0;
  logic          in_reset;
  logic          in_start;
  logic [1:0]    in_choosen_type;
  logic [IW-1:0] in_choosen_index;
  logic [3:0]    in_random;
  logic [VW-1:0] in_int_min;
  logic [VW-1:0] in_int_max;
  logic [VW-1:0] in_discrete_max;
  logic          out_mem_read_enable;
  logic [1:0]    out_mem_read_type;
  logic [IW-1:0] out_mem_read_index;
  logic [VW-1:0] in_mem_read_data;
  logic          out_proposal_valid;
  logic          in_proposal_ready;
  logic [1:0]    out_proposal_type;
  logic [IW-1:0] out_proposal_index;
  logic [VW-1:0] out_old_value;
  logic [VW-1:0] out_new_value;
  logic          out_busy;
  logic          out_error;

  typedef struct packed {
    logic [1:0]    t;
    logic [IW-1:0] idx;
    logic [VW-1:0] old_v;
    logic [VW-1:0] new_v;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          last_exp;
  logic [VW-1:0] mem_value;
  int            vectors = 0;
  int            miscompares = 0;

  variable_proposer #(
    .MAX_BIT_WIDTH_OF_VARIABLES_INDEX(IW),
    .VALUE_WIDTH(VW)
  ) dut (
    .in_clock            (in_clock),
    .in_reset            (in_reset),
    .in_start            (in_start),
    .in_choosen_type     (in_choosen_type),
    .in_choosen_index    (in_choosen_index),
    .in_random           (in_random),
    .in_int_min          (in_int_min),
    .in_int_max          (in_int_max),
    .in_discrete_max     (in_discrete_max),
    .out_mem_read_enable (out_mem_read_enable),
    .out_mem_read_type   (out_mem_read_type),
    .out_mem_read_index  (out_mem_read_index),
    .in_mem_read_data    (in_mem_read_data),
    .out_proposal_valid  (out_proposal_valid),
    .in_proposal_ready   (in_proposal_ready),
    .out_proposal_type   (out_proposal_type),
    .out_proposal_index  (out_proposal_index),
    .out_old_value       (out_old_value),
    .out_new_value       (out_new_value),
    .out_busy            (out_busy),
    .out_error           (out_error)
  );

  always #5 in_clock = ~in_clock;

  // Assignment memory: returns the bench's current value one cycle after a read.
  always @(posedge in_clock or posedge in_reset) begin
    if (in_reset) in_mem_read_data <= '0;
    else if (out_mem_read_enable) in_mem_read_data <= mem_value;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge in_clock);
    #1;
  endtask

  function automatic logic [VW-1:0] ref_new(input logic [1:0] t, input logic [VW-1:0] old,
                                            input logic [3:0] rnd);
    int o, m, f, mn, mx, dm;
    logic [VW-1:0] r;
    o  = int'($signed(old));
    mn = int'($signed(in_int_min));
    mx = int'($signed(in_int_max));
    dm = int'(in_discrete_max);
    m  = int'(rnd[2:0]) + 1;
    r  = '0;
    if (t == 2'd0) begin
      r = {15'd0, ~old[0]};
    end else if (t == 2'd1) begin
      f = rnd[3] ? o - m : o + m;
      if (f > mx || f < mn) f = rnd[3] ? o + m : o - m;
      if (f > mx) f = mx;
      if (f < mn) f = mn;
      r = f[VW-1:0];
    end else if (t == 2'd2) begin
      o = int'(old);
      if (rnd[0] == 1'b0) f = (o == dm) ? 0 : o + 1;
      else f = (o == 0) ? dm : o - 1;
      r = f[VW-1:0];
    end
    return r;
  endfunction

  // Runs IDLE..VALID for one request; a legal proposal is left waiting in VALID.
  task automatic launch(input logic [1:0] t, input logic [IW-1:0] idx, input logic [3:0] rnd,
                        input logic [VW-1:0] old, input logic [VW-1:0] exp_new);
    exp_t e;
    e.t = t; e.idx = idx; e.old_v = old; e.new_v = exp_new;
    if (t != 2'd3) sb_q.push_back(e);
    mem_value = old;
    in_choosen_type = t; in_choosen_index = idx; in_random = rnd; in_start = 1'b1;
    step();
    in_start = 1'b0;
    in_choosen_type = 2'd0; in_choosen_index = '0; in_random = 4'd0;
    check("read_en", out_mem_read_enable, 1);
    check("read_addr", {out_mem_read_type, out_mem_read_index}, {t, idx});
    check("busy", out_busy, 1);
    step();
    check("read_en_1cyc", {out_mem_read_enable, out_proposal_valid}, 0);
    step();
    check("early_valid", out_proposal_valid, 0);
    check("error_compute", out_error, (t == 2'd3));
    step();
    if (t == 2'd3) begin
      check("error_done", {out_error, out_proposal_valid, out_busy}, 0);
    end else begin
      check("valid_edge4", {out_proposal_valid, out_busy, out_error}, 3'b110);
      if (sb_q.size() == 0) begin
        check("sb_empty", 0, 1);
      end else begin
        last_exp = sb_q.pop_front();
        check("prop_type", out_proposal_type, last_exp.t);
        check("prop_index", out_proposal_index, last_exp.idx);
        check("prop_old", out_old_value, last_exp.old_v);
        check("prop_new", out_new_value, last_exp.new_v);
      end
    end
  endtask

  task automatic accept(input int hold, input logic start_too);
    in_proposal_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", out_proposal_valid, 1);
      check("hold_data", {out_proposal_type, out_proposal_index, out_old_value, out_new_value},
            last_exp);
    end
    in_proposal_ready = 1'b1;
    in_start = start_too;
    in_choosen_type = 2'd1;
    step();
    in_proposal_ready = 1'b0;
    in_start = 1'b0;
    check("xfer_done", {out_proposal_valid, out_busy}, 0);
    step();
    check("idle_after", {out_busy, out_mem_read_enable}, 0);
  endtask

  initial begin
    logic [1:0]    t;
    logic [3:0]    rnd;
    logic [VW-1:0] old;
    in_reset = 1'b0; in_start = 1'b0; in_choosen_type = 2'd0; in_choosen_index = '0;
    in_random = 4'd0; in_proposal_ready = 1'b0; mem_value = '0;
    in_int_min = -16'sd10; in_int_max = 16'sd10; in_discrete_max = 16'd4;
    #1 in_reset = 1'b1;
    #2;
    check("reset_outs", {out_mem_read_enable, out_mem_read_type, out_mem_read_index,
                         out_proposal_valid, out_proposal_type, out_proposal_index,
                         out_busy, out_error}, 0);
    check("reset_vals", {out_old_value, out_new_value}, 0);
    #9 in_reset = 1'b0;
    step();

    launch(2'd0, 8'd3, 4'b0000, 16'd1, 16'd0);        accept(0, 1'b0);
    launch(2'd1, 8'd7, 4'b0010, 16'd5, 16'd8);        accept(0, 1'b0);
    launch(2'd1, 8'd8, 4'b0111, 16'd9, 16'd1);        accept(1, 1'b0);
    launch(2'd1, 8'd9, 4'b1111, 16'hFFF6, 16'hFFFE);  accept(0, 1'b0);
    launch(2'd1, 8'd2, 4'b0000, 16'd10, 16'd9);       accept(0, 1'b0);
    launch(2'd2, 8'd4, 4'b0000, 16'd4, 16'd0);        accept(0, 1'b0);
    launch(2'd2, 8'd5, 4'b0001, 16'd0, 16'd4);        accept(0, 1'b0);
    launch(2'd0, 8'hFF, 4'b1010, 16'hABCE, 16'd1);    accept(0, 1'b0);
    launch(2'd1, 8'd6, 4'b1000, 16'd2, 16'd1);        accept(5, 1'b1);

    // Reset while waiting for memory data: nothing may come out afterwards.
    mem_value = 16'd7;
    in_choosen_type = 2'd1; in_choosen_index = 8'd11; in_random = 4'b0001; in_start = 1'b1;
    step();
    in_start = 1'b0;
    step();
    #2 in_reset = 1'b1;
    #1;
    check("rst_mid_outs", {out_mem_read_enable, out_mem_read_type, out_mem_read_index,
                           out_proposal_valid, out_proposal_type, out_proposal_index,
                           out_busy, out_error}, 0);
    check("rst_mid_vals", {out_old_value, out_new_value}, 0);
    #2 in_reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("no_valid_after_rst", {out_proposal_valid, out_busy}, 0);
    end

    launch(2'd3, 8'd1, 4'b0000, 16'd3, 16'd0);
    step();
    check("illegal_quiet", {out_proposal_valid, out_error, out_busy}, 0);

    for (int i = 0; i < 8; i++) begin
      t   = 2'($urandom_range(0, 2));
      rnd = 4'($urandom_range(0, 15));
      if (t == 2'd1) old = 16'($urandom_range(0, 20)) - 16'd10;
      else if (t == 2'd2) old = 16'($urandom_range(0, 4));
      else old = 16'($urandom);
      launch(t, 8'($urandom), rnd, old, ref_new(t, old, rnd));
      accept($urandom_range(0, 2), 1'b0);
    end

    check("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
